// File: rtl/axi4_accel_slave.sv
// rtl/axi4_accel_slave.sv - AXI4 INCR burst slave fronting a compute core
// Holds NIN operand beats for the core, returns NOUT result beats plus a status beat.
module axi4_accel_slave #(
  parameter int DSZ  = 8,
  parameter int ASZ  = 4,
  parameter int NIN  = 8,
  parameter int NOUT = 8,
  parameter int LSZ  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ASZ-1:0]       awaddr,
  input  logic [LSZ-1:0]       awlen,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [DSZ-1:0]       wdata,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic                 wlast,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [ASZ-1:0]       araddr,
  input  logic [LSZ-1:0]       arlen,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [DSZ-1:0]       rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  output logic                 rlast,
  input  logic                 rready,
  output logic [NIN*DSZ-1:0]   core_a,
  input  logic [NOUT*DSZ-1:0]  core_res,
  output logic                 core_start,
  input  logic                 core_ready
);

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_ADDR, R_WAIT, R_DATA} rstate_t;

  localparam logic [ASZ-1:0] CTRL_ADDR = ASZ'(NIN);
  localparam logic [ASZ-1:0] STAT_ADDR = ASZ'(NOUT);

  wstate_t              wstate, wstate_nx;
  logic [ASZ-1:0]       waddr;
  logic [LSZ-1:0]       wcnt;
  logic                 werr;
  logic [NIN*DSZ-1:0]   core_a_q;
  logic                 start_q;
  logic                 busy;
  logic                 seen_low;

  rstate_t              rstate, rstate_nx;
  logic [ASZ-1:0]       raddr;
  logic [LSZ-1:0]       rcnt;
  logic [DSZ-1:0]       rdata_q;
  logic [1:0]           rresp_q;
  logic [ASZ-1:0]       sel_addr;
  logic [DSZ-1:0]       dec_data;
  logic [1:0]           dec_resp;

  logic w_hs, beat_last, ctrl_start, start_ok, start_rej, beat_bad;

  assign core_a     = core_a_q;
  assign core_start = start_q;
  assign bresp      = bvalid ? {werr, 1'b0} : 2'b00;
  assign rdata      = rdata_q;
  assign rresp      = rresp_q;
  assign rlast      = rvalid && (rcnt == '0);

  assign w_hs       = wvalid && wready;
  assign beat_last  = (wcnt == '0);
  assign ctrl_start = w_hs && (waddr == CTRL_ADDR) && wdata[0];
  assign start_ok   = ctrl_start && core_ready;
  assign start_rej  = ctrl_start && !core_ready;
  assign beat_bad   = (waddr > CTRL_ADDR) || (wlast != beat_last) || start_rej;

  always_comb begin
    wstate_nx = wstate;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (wstate)
      W_ADDR: begin
        awready = 1'b1;
        if (awvalid) wstate_nx = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && beat_last) wstate_nx = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wstate_nx = W_ADDR;
      end
      default: wstate_nx = W_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate   <= W_ADDR;
      waddr    <= '0;
      wcnt     <= '0;
      werr     <= 1'b0;
      core_a_q <= '0;
      start_q  <= 1'b0;
      busy     <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      wstate  <= wstate_nx;
      start_q <= start_ok;
      if (awvalid && awready) begin
        waddr <= awaddr;
        wcnt  <= awlen;
        werr  <= 1'b0;
      end
      if (w_hs) begin
        waddr <= waddr + ASZ'(1);
        wcnt  <= wcnt - LSZ'(1);
        if (beat_bad) werr <= 1'b1;
        for (int i = 0; i < NIN; i++) begin
          if (waddr == ASZ'(i)) core_a_q[i*DSZ +: DSZ] <= wdata;
        end
      end
      // Busy spans one full core run: core_ready must drop and then return.
      if (start_ok) begin
        busy     <= 1'b1;
        seen_low <= 1'b0;
      end else if (busy) begin
        if (!core_ready) begin
          seen_low <= 1'b1;
        end else if (seen_low) begin
          busy     <= 1'b0;
          seen_low <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    case (rstate)
      R_WAIT:  sel_addr = raddr;
      R_DATA:  sel_addr = raddr + ASZ'(1);
      default: sel_addr = araddr;
    endcase
  end

  always_comb begin
    dec_data = '0;
    dec_resp = 2'b00;
    for (int j = 0; j < NOUT; j++) begin
      if (sel_addr == ASZ'(j)) dec_data = core_res[j*DSZ +: DSZ];
    end
    if (sel_addr == STAT_ADDR) begin
      dec_data = DSZ'({busy, core_ready});
    end else if (sel_addr > STAT_ADDR) begin
      dec_resp = 2'b10;
    end
  end

  always_comb begin
    rstate_nx = rstate;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (rstate)
      R_ADDR: begin
        arready = 1'b1;
        if (arvalid) begin
          if (core_ready || ((araddr == STAT_ADDR) && (arlen == '0))) rstate_nx = R_DATA;
          else rstate_nx = R_WAIT;
        end
      end
      R_WAIT: begin
        if (core_ready) rstate_nx = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && (rcnt == '0)) rstate_nx = R_ADDR;
      end
      default: rstate_nx = R_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate  <= R_ADDR;
      raddr   <= '0;
      rcnt    <= '0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else begin
      rstate <= rstate_nx;
      case (rstate)
        R_ADDR: begin
          if (arvalid) begin
            raddr <= araddr;
            rcnt  <= arlen;
            if (rstate_nx == R_DATA) begin
              rdata_q <= dec_data;
              rresp_q <= dec_resp;
            end
          end
        end
        R_WAIT: begin
          if (core_ready) begin
            rdata_q <= dec_data;
            rresp_q <= dec_resp;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rcnt == '0) begin
              rdata_q <= '0;
              rresp_q <= 2'b00;
            end else begin
              raddr   <= raddr + ASZ'(1);
              rcnt    <= rcnt - LSZ'(1);
              rdata_q <= dec_data;
              rresp_q <= dec_resp;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_accel_slave.sv
// tb/tb_axi4_accel_slave.sv - self-checking bench for axi4_accel_slave
// Scoreboard queues hold expected B responses and R beats computed from the bench's own core model.
module tb_axi4_accel_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr, awlen, arlen;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [7:0]  wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic [63:0] core_a, core_res;
  logic        core_start, core_ready;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int stall_viol = 0;
  time first_rv;
  logic [1:0] bq[$];
  logic [7:0] rq_data[$];
  logic [1:0] rq_resp[$];
  logic [7:0] od[$];
  logic [1:0] orr[$];
  logic       ol[$];

  axi4_accel_slave #(.DSZ(8), .ASZ(4), .NIN(8), .NOUT(8), .LSZ(4)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .core_a(core_a), .core_res(core_res), .core_start(core_start), .core_ready(core_ready)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (core_start) start_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [3:0] len, input logic [127:0] d,
                           input int last_at, output logic [1:0] resp, output int b_wait, output bit tmo);
    int n;
    tmo = 0;
    awaddr = addr; awlen = len; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick; n++; end
    if (n >= 50) tmo = 1;
    tick;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d[i*8 +: 8]; wlast = (i == last_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin tick; n++; end
      if (n >= 50) tmo = 1;
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick; n++; end
    if (n >= 50) tmo = 1;
    b_wait = n;
    resp = bresp;
    bready = 1'b1;
    tick;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [3:0] len, input bit toggle, output bit tmo);
    int n, cyc;
    bit done, stalled;
    logic [7:0] hd;
    logic [1:0] hr;
    od.delete(); orr.delete(); ol.delete();
    first_rv = 0;
    araddr = addr; arlen = len; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick; n++; end
    tick;
    arvalid = 1'b0;
    done = 0; stalled = 0; cyc = 0;
    while (!done && cyc < 200) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rvalid) begin
        if (first_rv == 0) first_rv = $time;
        if (stalled && (rdata !== hd || rresp !== hr)) stall_viol++;
        if (rready) begin
          od.push_back(rdata); orr.push_back(rresp); ol.push_back(rlast);
          stalled = 0;
          if (rlast) done = 1;
        end else begin
          stalled = 1; hd = rdata; hr = rresp;
        end
      end
      tick;
      cyc++;
    end
    rready = 1'b0;
    tmo = !done;
  endtask

  function automatic void push_exp(input logic [3:0] addr, input logic [3:0] len, input logic [7:0] status);
    logic [3:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 4'(i);
      if (a < 4'd8) begin rq_data.push_back(core_res[a*8 +: 8]); rq_resp.push_back(2'b00); end
      else if (a == 4'd8) begin rq_data.push_back(status); rq_resp.push_back(2'b00); end
      else begin rq_data.push_back(8'h00); rq_resp.push_back(2'b10); end
    end
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++;
    if ({awready, arready, wready, bvalid, bresp, rvalid, rlast, rresp, core_start} !== 11'b11000000000) begin
      failures++; $display("FAIL reset_ctrl got %b exp 11000000000",
        {awready, arready, wready, bvalid, bresp, rvalid, rlast, rresp, core_start});
    end
    checks++;
    if (core_a !== 64'h0 || rdata !== 8'h0) begin
      failures++; $display("FAIL reset_data got core_a=%h rdata=%h exp 0", core_a, rdata);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_write_burst;
    logic [1:0] resp; int bw; bit tmo; logic [1:0] e;
    bq.push_back(2'b00);
    axi_write(4'd0, 4'd7, 128'h0807060504030201, 7, resp, bw, tmo);
    e = bq.pop_front();
    checks++;
    if (tmo || resp !== e) begin failures++; $display("FAIL wr_burst_resp got %b tmo=%0d exp %b", resp, tmo, e); end
    checks++;
    if (bw !== 0) begin failures++; $display("FAIL wr_burst_blat got %0d exp 0", bw); end
    checks++;
    if (core_a !== 64'h0807060504030201) begin
      failures++; $display("FAIL wr_burst_core_a got %h exp 0807060504030201", core_a);
    end
  endtask

  task automatic test_start;
    logic [1:0] resp; int bw, s0, n; bit tmo; logic [1:0] e;
    core_ready = 1'b1;
    s0 = start_cnt;
    bq.push_back(2'b00);
    axi_write(4'd8, 4'd0, 128'h01, 0, resp, bw, tmo);
    e = bq.pop_front();
    checks++;
    if (tmo || resp !== e) begin failures++; $display("FAIL start_ok_resp got %b exp %b", resp, e); end
    checks++;
    if (start_cnt - s0 !== 1) begin failures++; $display("FAIL start_pulse got %0d cycles exp 1", start_cnt - s0); end
    push_exp(4'd8, 4'd0, 8'h03);
    axi_read(4'd8, 4'd0, 0, tmo);
    checks++;
    if (tmo || od.size() != 1 || od[0] !== rq_data[0] || orr[0] !== rq_resp[0]) begin
      failures++; $display("FAIL status_busy got %h exp %h", od.size() ? od[0] : 8'hxx, rq_data[0]);
    end
    rq_data.delete(); rq_resp.delete();
    core_ready = 1'b0;
    tick; tick; tick;
    core_ready = 1'b1;
    tick;
    push_exp(4'd8, 4'd0, 8'h01);
    axi_read(4'd8, 4'd0, 0, tmo);
    checks++;
    if (tmo || od.size() != 1 || od[0] !== rq_data[0]) begin
      failures++; $display("FAIL status_idle got %h exp %h", od.size() ? od[0] : 8'hxx, rq_data[0]);
    end
    rq_data.delete(); rq_resp.delete();
    core_ready = 1'b0;
    s0 = start_cnt;
    bq.push_back(2'b10);
    axi_write(4'd8, 4'd0, 128'h01, 0, resp, bw, tmo);
    e = bq.pop_front();
    checks++;
    if (tmo || resp !== e) begin failures++; $display("FAIL start_rej_resp got %b exp %b", resp, e); end
    n = start_cnt - s0;
    checks++;
    if (n !== 0) begin failures++; $display("FAIL start_rej_pulse got %0d exp 0", n); end
    push_exp(4'd8, 4'd0, 8'h00);
    axi_read(4'd8, 4'd0, 0, tmo);
    checks++;
    if (tmo || od.size() != 1 || od[0] !== rq_data[0]) begin
      failures++; $display("FAIL status_skip_wait got %h tmo=%0d exp %h", od.size() ? od[0] : 8'hxx, tmo, rq_data[0]);
    end
    rq_data.delete(); rq_resp.delete();
    core_ready = 1'b1;
  endtask

  task automatic test_read_wait;
    bit tmo; time rdy_t; int n;
    core_res = 64'h1122334455667788;
    core_ready = 1'b0;
    push_exp(4'd0, 4'd7, 8'h00);
    fork
      axi_read(4'd0, 4'd7, 0, tmo);
      begin repeat (6) tick; rdy_t = $time; core_ready = 1'b1; end
    join
    checks++;
    if (tmo || first_rv !== rdy_t + 10) begin
      failures++; $display("FAIL rd_wait_first got %0t exp %0t tmo=%0d", first_rv, rdy_t + 10, tmo);
    end
    n = rq_data.size();
    checks++;
    if (od.size() != n) begin failures++; $display("FAIL rd_wait_count got %0d exp %0d", od.size(), n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (od[i] !== rq_data[0] || orr[i] !== rq_resp[0] || ol[i] !== (i == n - 1)) begin
        failures++; $display("FAIL rd_wait_beat%0d got %h/%b/%b exp %h/%b/%b", i, od[i], orr[i], ol[i],
          rq_data[0], rq_resp[0], i == n - 1);
      end
      void'(rq_data.pop_front()); void'(rq_resp.pop_front());
    end
  endtask

  task automatic test_read_boundary;
    bit tmo; int n;
    core_ready = 1'b1;
    push_exp(4'd7, 4'd3, 8'h01);
    push_exp(4'd15, 4'd1, 8'h01);
    axi_read(4'd7, 4'd3, 0, tmo);
    checks++;
    if (tmo || od.size() != 4) begin failures++; $display("FAIL rd_bnd_count got %0d exp 4", od.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od[i] !== rq_data[0] || orr[i] !== rq_resp[0] || ol[i] !== (i == 3)) begin
        failures++; $display("FAIL rd_bnd_beat%0d got %h/%b exp %h/%b", i, od[i], orr[i], rq_data[0], rq_resp[0]);
      end
      void'(rq_data.pop_front()); void'(rq_resp.pop_front());
    end
    axi_read(4'd15, 4'd1, 0, tmo);
    n = rq_data.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (tmo || od[i] !== rq_data[0] || orr[i] !== rq_resp[0] || ol[i] !== (i == n - 1)) begin
        failures++; $display("FAIL rd_wrap_beat%0d got %h/%b exp %h/%b", i, od[i], orr[i], rq_data[0], rq_resp[0]);
      end
      void'(rq_data.pop_front()); void'(rq_resp.pop_front());
    end
  endtask

  task automatic test_read_stall;
    bit tmo; int n;
    core_res = 64'hA1B2C3D4E5F60718;
    stall_viol = 0;
    push_exp(4'd0, 4'd7, 8'h01);
    axi_read(4'd0, 4'd7, 1, tmo);
    checks++;
    if (tmo || stall_viol !== 0) begin failures++; $display("FAIL rd_stall_hold got %0d changes exp 0", stall_viol); end
    n = rq_data.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (od[i] !== rq_data[0] || orr[i] !== rq_resp[0] || ol[i] !== (i == n - 1)) begin
        failures++; $display("FAIL rd_stall_beat%0d got %h/%b/%b exp %h/%b", i, od[i], orr[i], ol[i], rq_data[0], rq_resp[0]);
      end
      void'(rq_data.pop_front()); void'(rq_resp.pop_front());
    end
  endtask

  task automatic test_wlast_and_wrap;
    logic [1:0] resp; int bw; bit tmo; logic [1:0] e;
    bq.push_back(2'b10); bq.push_back(2'b10); bq.push_back(2'b10);
    axi_write(4'd0, 4'd3, 128'h44332211, 1, resp, bw, tmo);
    e = bq.pop_front();
    checks++;
    if (tmo || resp !== e || core_a[31:0] !== 32'h44332211) begin
      failures++; $display("FAIL wlast_early got %b/%h exp %b/44332211", resp, core_a[31:0], e);
    end
    axi_write(4'd4, 4'd3, 128'h88776655, -1, resp, bw, tmo);
    e = bq.pop_front();
    checks++;
    if (tmo || resp !== e || core_a[63:32] !== 32'h88776655) begin
      failures++; $display("FAIL wlast_missing got %b/%h exp %b/88776655", resp, core_a[63:32], e);
    end
    axi_write(4'd14, 4'd3, 128'hBBAAF0E0, 3, resp, bw, tmo);
    e = bq.pop_front();
    checks++;
    if (tmo || resp !== e || core_a !== 64'h887766554433BBAA) begin
      failures++; $display("FAIL wr_wrap got %b/%h exp %b/887766554433bbaa", resp, core_a, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] resp; int bw; bit tmo_w, tmo_r; logic [1:0] e; int n;
    core_res = 64'h0F1E2D3C4B5A6978;
    bq.push_back(2'b00);
    push_exp(4'd0, 4'd7, 8'h01);
    fork
      axi_write(4'd0, 4'd7, 128'hC7C6C5C4C3C2C1C0, 7, resp, bw, tmo_w);
      axi_read(4'd0, 4'd7, 0, tmo_r);
    join
    e = bq.pop_front();
    checks++;
    if (tmo_w || resp !== e || core_a !== 64'hC7C6C5C4C3C2C1C0) begin
      failures++; $display("FAIL b2b_write got %b/%h exp %b/c7c6c5c4c3c2c1c0", resp, core_a, e);
    end
    n = rq_data.size();
    checks++;
    if (tmo_r || od.size() != n) begin failures++; $display("FAIL b2b_read_count got %0d exp %0d", od.size(), n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (od[i] !== rq_data[0] || ol[i] !== (i == n - 1)) begin
        failures++; $display("FAIL b2b_beat%0d got %h exp %h", i, od[i], rq_data[0]);
      end
      void'(rq_data.pop_front()); void'(rq_resp.pop_front());
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] resp; int bw, spur; bit tmo; logic [1:0] e;
    core_ready = 1'b0;
    araddr = 4'd0; arlen = 4'd7; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    awaddr = 4'd0; awlen = 4'd7; awvalid = 1'b1;
    tick;
    awvalid = 1'b0; wdata = 8'h5A; wvalid = 1'b1; wlast = 1'b0;
    tick; tick;
    wvalid = 1'b0;
    rst = 1'b1;
    tick;
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000 || core_a !== 64'h0) begin
      failures++; $display("FAIL rst_mid got %b core_a=%h exp 110000 core_a=0",
        {awready, arready, wready, bvalid, rvalid, rlast}, core_a);
    end
    rst = 1'b0;
    core_ready = 1'b1;
    spur = 0;
    repeat (4) begin tick; if (bvalid || rvalid) spur++; end
    checks++;
    if (spur !== 0) begin failures++; $display("FAIL rst_mid_spurious got %0d exp 0", spur); end
    bq.push_back(2'b00);
    axi_write(4'd0, 4'd1, 128'hBEEF, 1, resp, bw, tmo);
    e = bq.pop_front();
    checks++;
    if (tmo || resp !== e || core_a !== 64'h000000000000BEEF) begin
      failures++; $display("FAIL rst_mid_recover got %b/%h exp %b/beef", resp, core_a, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    core_res = 64'h0; core_ready = 1'b1;
    test_reset;
    test_write_burst;
    test_start;
    test_read_wait;
    test_read_boundary;
    test_read_stall;
    test_wlast_and_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
